// File: rtl/train_scheduler.sv
// Training-run sequencer: fetches samples by index, streams them into the network, meters
// in-flight samples and forwards inference results. Define SCHED_ACCURACY_EN for oCorrect.
module train_scheduler #(
  parameter int unsigned NI    = 4,
  parameter int unsigned NO    = 7,
  parameter int unsigned WV    = 8,
  parameter int unsigned WO    = 12,
  parameter int unsigned NS    = 16,
  parameter int unsigned MAXIF = 4,
  parameter int unsigned WE    = 16,
  localparam int unsigned AW   = (NS > 1) ? $clog2(NS) : 1
) (
  input  logic                 iCLK,
  input  logic                 iRST,
`ifdef SCHED_ACCURACY_EN
  output logic [$clog2(NS+1)-1:0] oCorrect,
`endif
  input  logic                 iStart,
  input  logic [WE-1:0]        iEpochs,
  input  logic [WV-1:0]        iLR,
  output logic                 oMode,
  output logic [WV-1:0]        oLR,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [WE-1:0]        oEpoch,
  output logic [AW-1:0]        oAddr,
  input  logic [NI*WV-1:0]     iData_Sample,
  input  logic [NO*WO-1:0]     iData_Label,
  output logic                 oValid_BM_Input,
  input  logic                 iReady_BM_Input,
  output logic [NI*WV-1:0]     oData_BM_Input,
  output logic                 oValid_BM_Teacher,
  input  logic                 iReady_BM_Teacher,
  output logic [NO*WO-1:0]     oData_BM_Teacher,
  input  logic                 iValid_AM_Output,
  output logic                 oReady_AM_Output,
  input  logic [NO*WO-1:0]     iData_AM_Output,
  output logic                 oValid_BM_Result,
  input  logic                 iReady_BM_Result,
  output logic [NO*WO-1:0]     oData_BM_Result
);

  localparam int unsigned CW = $clog2(MAXIF + 1);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StIssue, StDrain} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q;
  logic [WE-1:0]     epoch_q, epochs_q;
  logic [WV-1:0]     lr_q;
  logic              mode_q;
  logic              in_vld_q, tch_vld_q;
  logic [NI*WV-1:0]  in_data_q;
  logic [NO*WO-1:0]  tch_data_q;
  logic [CW-1:0]     inflight_q;
  logic              in_hs, out_hs, last_epoch;

  assign in_hs      = in_vld_q && iReady_BM_Input;
  assign out_hs     = iValid_AM_Output && oReady_AM_Output;
  assign last_epoch = ({1'b0, epoch_q} + (WE+1)'(1)) >= {1'b0, epochs_q};

  always_ff @(posedge iCLK) begin
    if (iRST) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (iStart) state_d = StFetch;
      StFetch: if (inflight_q != CW'(MAXIF)) state_d = StLoad;
      StLoad:  state_d = StIssue;
      StIssue: begin
        if (!in_vld_q && !tch_vld_q) state_d = (addr_q == AW'(NS - 1)) ? StDrain : StFetch;
      end
      StDrain: if (inflight_q == '0) state_d = mode_q ? StFetch : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    oBusy            = (state_q != StIdle);
    oDone            = (state_q == StDrain) && (inflight_q == '0) && !mode_q;
    oValid_BM_Result = !mode_q && iValid_AM_Output;
    oReady_AM_Output = mode_q || iReady_BM_Result;
    oData_BM_Result  = iData_AM_Output;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      addr_q     <= '0;
      epoch_q    <= '0;
      epochs_q   <= '0;
      lr_q       <= '0;
      mode_q     <= 1'b0;
      in_vld_q   <= 1'b0;
      tch_vld_q  <= 1'b0;
      in_data_q  <= '0;
      tch_data_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (iStart) begin
            epochs_q <= iEpochs;
            lr_q     <= iLR;
            addr_q   <= '0;
            epoch_q  <= '0;
            mode_q   <= (iEpochs != '0);
          end
        end
        StLoad: begin
          in_data_q  <= iData_Sample;
          tch_data_q <= iData_Label;
          in_vld_q   <= 1'b1;
          tch_vld_q  <= mode_q;
        end
        StIssue: begin
          if (in_hs) in_vld_q <= 1'b0;
          if (tch_vld_q && iReady_BM_Teacher) tch_vld_q <= 1'b0;
          if (!in_vld_q && !tch_vld_q && addr_q != AW'(NS - 1)) addr_q <= addr_q + 1'b1;
        end
        StDrain: begin
          if (inflight_q == '0 && mode_q) begin
            addr_q <= '0;
            // Last training epoch rolls into the inference pass without bumping the epoch.
            if (last_epoch) mode_q  <= 1'b0;
            else            epoch_q <= epoch_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      inflight_q <= '0;
    end else if (in_hs && !out_hs) begin
      inflight_q <= inflight_q + 1'b1;
    end else if (out_hs && !in_hs && inflight_q != '0) begin
      inflight_q <= inflight_q - 1'b1;
    end
  end

  assign oMode             = mode_q;
  assign oLR               = lr_q;
  assign oEpoch            = epoch_q;
  assign oAddr             = addr_q;
  assign oValid_BM_Input   = in_vld_q;
  assign oData_BM_Input    = in_data_q;
  assign oValid_BM_Teacher = tch_vld_q;
  assign oData_BM_Teacher  = tch_data_q;

`ifdef SCHED_ACCURACY_EN
  localparam int unsigned IW = (NO > 1) ? $clog2(NO) : 1;
  localparam int unsigned PW = (MAXIF > 1) ? $clog2(MAXIF) : 1;

  // Unsigned argmax; strict compare keeps the lowest index on ties.
  function automatic logic [IW-1:0] argmax(input logic [NO*WO-1:0] v);
    logic [IW-1:0] idx;
    logic [WO-1:0] best;
    idx  = '0;
    best = v[WO-1:0];
    for (int unsigned i = 1; i < NO; i++) begin
      if (v[i*WO +: WO] > best) begin
        best = v[i*WO +: WO];
        idx  = IW'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAXIF - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [IW-1:0]           fifo_q [MAXIF];
  logic [PW-1:0]           wptr_q, rptr_q;
  logic [CW-1:0]           fcnt_q;
  logic [$clog2(NS+1)-1:0] correct_q;
  logic                    push, pop, start;

  assign start = (state_q == StIdle) && iStart;
  assign push  = in_hs && !mode_q;
  assign pop   = oValid_BM_Result && iReady_BM_Result && (fcnt_q != '0);

  always_ff @(posedge iCLK) begin
    if (push) fifo_q[wptr_q] <= argmax(tch_data_q);
  end

  always_ff @(posedge iCLK) begin
    if (iRST || start) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      fcnt_q    <= '0;
      correct_q <= '0;
    end else begin
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      if (push && !pop)      fcnt_q <= fcnt_q + 1'b1;
      else if (pop && !push) fcnt_q <= fcnt_q - 1'b1;
      if (pop && fifo_q[rptr_q] == argmax(iData_AM_Output)) correct_q <= correct_q + 1'b1;
    end
  end

  assign oCorrect = correct_q;
`endif

endmodule

// File: tb/tb_train_scheduler.sv
// Directed bench for train_scheduler: sample memory, echo network and a transaction-level
// model that predicts every handshake from the run's epoch count.
module tb_train_scheduler;
  localparam int unsigned NI = 4, NO = 7, WV = 8, WO = 12, NS = 4, MAXIF = 2, WE = 16;
  localparam int unsigned AW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              iRST, iStart;
  logic [WE-1:0]     iEpochs;
  logic [WV-1:0]     iLR;
  logic              oMode, oBusy, oDone;
  logic [WV-1:0]     oLR;
  logic [WE-1:0]     oEpoch;
  logic [AW-1:0]     oAddr;
  logic [NI*WV-1:0]  iData_Sample, oData_BM_Input;
  logic [NO*WO-1:0]  iData_Label, oData_BM_Teacher, iData_AM_Output, oData_BM_Result;
  logic oValid_BM_Input, iReady_BM_Input, oValid_BM_Teacher, iReady_BM_Teacher;
  logic iValid_AM_Output, oReady_AM_Output, oValid_BM_Result, iReady_BM_Result;

  train_scheduler #(
    .NI(NI), .NO(NO), .WV(WV), .WO(WO), .NS(NS), .MAXIF(MAXIF), .WE(WE)
  ) dut (
    .iCLK(clk), .iRST(iRST), .iStart(iStart), .iEpochs(iEpochs), .iLR(iLR),
    .oMode(oMode), .oLR(oLR), .oBusy(oBusy), .oDone(oDone), .oEpoch(oEpoch), .oAddr(oAddr),
    .iData_Sample(iData_Sample), .iData_Label(iData_Label),
    .oValid_BM_Input(oValid_BM_Input), .iReady_BM_Input(iReady_BM_Input),
    .oData_BM_Input(oData_BM_Input),
    .oValid_BM_Teacher(oValid_BM_Teacher), .iReady_BM_Teacher(iReady_BM_Teacher),
    .oData_BM_Teacher(oData_BM_Teacher),
    .iValid_AM_Output(iValid_AM_Output), .oReady_AM_Output(oReady_AM_Output),
    .iData_AM_Output(iData_AM_Output),
    .oValid_BM_Result(oValid_BM_Result), .iReady_BM_Result(iReady_BM_Result),
    .oData_BM_Result(oData_BM_Result)
  );

  int n_pass = 0, n_total = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [NI*WV-1:0] samp(input int a);
    return {8'(a * 16 + 1), 8'(a * 16 + 2), 8'(a + 48), 8'(160 + a)};
  endfunction

  function automatic logic [NO*WO-1:0] lab(input int a);
    logic [NO*WO-1:0] v;
    for (int i = 0; i < int'(NO); i++) v[i*WO +: WO] = 12'(100 * (a + 1) + i);
    return v;
  endfunction

  // Sample memory, one-cycle read latency.
  always @(posedge clk) begin
    iData_Sample <= samp(int'(oAddr));
    iData_Label  <= lab(int'(oAddr));
  end

  // Stimulus-owned run description.
  bit        net_stall = 1'b0;
  int        run_id = 0, run_epochs = 0;
  logic [WV-1:0] run_lr = '0;

  // Echo network: each accepted input reappears on the output stream three cycles later.
  logic [NO*WO-1:0] nq_data[$];
  int               nq_due[$];
  initial begin
    bit hs_in, hs_out, rst;
    logic [NI*WV-1:0] d;
    iValid_AM_Output = 1'b0;
    iData_AM_Output  = '0;
    forever begin
      @(negedge clk);
      rst    = iRST;
      hs_in  = oValid_BM_Input && iReady_BM_Input;
      hs_out = iValid_AM_Output && oReady_AM_Output;
      d      = oData_BM_Input;
      @(posedge clk);
      #1;
      if (rst) begin
        nq_data.delete();
        nq_due.delete();
      end else begin
        if (hs_out) begin
          void'(nq_data.pop_front());
          void'(nq_due.pop_front());
        end
        if (hs_in) begin
          nq_data.push_back((NO*WO)'(d));
          nq_due.push_back(cyc + 3);
        end
      end
      iValid_AM_Output = !net_stall && nq_data.size() > 0 && nq_due[0] <= cyc;
      iData_AM_Output  = (nq_data.size() > 0) ? nq_data[0] : '0;
    end
  end

  // Transaction model: the k-th input of a run is sample k%NS, in training mode while
  // k < NS*epochs; results arrive in sample order during the inference pass.
  int n_in = 0, n_teach = 0, n_res = 0, n_done = 0, inflight_m = 0, last_run = 0;
  logic [NI*WV-1:0] first_in_data;
  logic [NO*WO-1:0] last_teach_data, last_res_data;
  initial begin
    bit prev_mode, prev_in_v, prev_t_v, hs_i, hs_o;
    logic [NI*WV-1:0] prev_in_d;
    logic [NO*WO-1:0] prev_t_d;
    prev_mode = 1'b0; prev_in_v = 1'b0; prev_t_v = 1'b0;
    prev_in_d = '0;   prev_t_d = '0;
    forever begin
      @(negedge clk);
      if (run_id != last_run) begin
        last_run = run_id;
        n_in = 0; n_teach = 0; n_res = 0; n_done = 0;
      end
      if (iRST) begin
        inflight_m = 0;
        prev_mode = 1'b0; prev_in_v = 1'b0; prev_t_v = 1'b0;
      end else begin
        if (oMode !== prev_mode) check("mode_change_drained", 128'(inflight_m), 128'(0));
        prev_mode = oMode;
        check("ready_route", 128'(oReady_AM_Output), 128'(oMode || iReady_BM_Result));
        check("result_valid_route", 128'(oValid_BM_Result), 128'(!oMode && iValid_AM_Output));
        if (oBusy) check("lr_latched", 128'(oLR), 128'(run_lr));
        if (oValid_BM_Teacher) check("teacher_only_train", 128'(oMode), 128'(1));
        if (prev_in_v) check("input_hold", 128'({oValid_BM_Input, oData_BM_Input}),
                             128'({1'b1, prev_in_d}));
        if (prev_t_v) check("teacher_hold", 128'({oValid_BM_Teacher, oData_BM_Teacher}),
                            128'({1'b1, prev_t_d}));
        prev_in_v = oValid_BM_Input && !iReady_BM_Input;
        prev_in_d = oData_BM_Input;
        prev_t_v  = oValid_BM_Teacher && !iReady_BM_Teacher;
        prev_t_d  = oData_BM_Teacher;

        hs_i = oValid_BM_Input && iReady_BM_Input;
        hs_o = iValid_AM_Output && oReady_AM_Output;
        if (hs_i) begin
          check("input_data", 128'(oData_BM_Input), 128'(samp(n_in % int'(NS))));
          check("input_mode", 128'(oMode), 128'(n_in < int'(NS) * run_epochs));
          if (n_in == 0) first_in_data = oData_BM_Input;
          n_in++;
        end
        if (oValid_BM_Teacher && iReady_BM_Teacher) begin
          check("teacher_data", 128'(oData_BM_Teacher), 128'(lab(n_teach % int'(NS))));
          last_teach_data = oData_BM_Teacher;
          n_teach++;
          check("teacher_count", 128'(n_teach <= int'(NS) * run_epochs), 128'(1));
        end
        if (oValid_BM_Result && iReady_BM_Result) begin
          check("result_data", 128'(oData_BM_Result), 128'((NO*WO)'(samp(n_res))));
          last_res_data = oData_BM_Result;
          n_res++;
        end
        if (hs_i && !hs_o) inflight_m++;
        else if (hs_o && !hs_i && inflight_m > 0) inflight_m--;
        if (hs_i) check("inflight_bound", 128'(inflight_m <= int'(MAXIF)), 128'(1));
        if (oDone) begin
          n_done++;
          check("done_all_results", 128'(n_res), 128'(NS));
          check("done_all_inputs", 128'(n_in), 128'(int'(NS) * (run_epochs + 1)));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input int e, input logic [WV-1:0] lr);
    run_epochs = e;
    run_lr     = lr;
    run_id++;
    iEpochs = WE'(e);
    iLR     = lr;
    iStart  = 1'b1;
    tick(1);
    iStart  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (oDone) break;
      tick(1);
    end
    check("done_seen", 128'(oDone), 128'(1));
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iRST = 1'b1; iStart = 1'b0; iEpochs = '0; iLR = '0;
    iReady_BM_Input = 1'b1; iReady_BM_Teacher = 1'b1; iReady_BM_Result = 1'b1;
    tick(3);
    check("rst_valid_in", 128'(oValid_BM_Input), 128'(0));
    check("rst_valid_teach", 128'(oValid_BM_Teacher), 128'(0));
    check("rst_valid_res", 128'(oValid_BM_Result), 128'(0));
    check("rst_mode", 128'(oMode), 128'(0));
    check("rst_busy", 128'(oBusy), 128'(0));
    check("rst_done", 128'(oDone), 128'(0));
    check("rst_epoch", 128'(oEpoch), 128'(0));
    check("rst_addr", 128'(oAddr), 128'(0));
    check("rst_lr", 128'(oLR), 128'(0));
    iRST = 1'b0;
    tick(2);

    // Two training epochs then inference.
    start(2, 8'h5A);
    wait_done(2000);
    check("t1_inputs", 128'(n_in), 128'(12));
    check("t1_teachers", 128'(n_teach), 128'(8));
    check("t1_results", 128'(n_res), 128'(4));
    check("t1_epoch", 128'(oEpoch), 128'(1));
    check("t1_first_input", 128'(first_in_data), 128'(32'h010230A0));
    check("t1_last_teacher", 128'(last_teach_data), 128'(84'h196195194193192191190));
    check("t1_last_result", 128'(last_res_data), 128'(84'h313233A3));
    tick(3);
    check("t1_done_once", 128'(n_done), 128'(1));
    check("t1_idle", 128'(oBusy), 128'(0));
    check("t1_epoch_hold", 128'(oEpoch), 128'(1));

    // Network output stalled: credit limit holds FETCH at addr 2.
    net_stall = 1'b1;
    start(1, 8'h11);
    tick(40);
    check("t2_inputs_capped", 128'(n_in), 128'(MAXIF));
    check("t2_addr_hold", 128'(oAddr), 128'(2));
    check("t2_no_valid", 128'(oValid_BM_Input), 128'(0));
    check("t2_busy", 128'(oBusy), 128'(1));
    net_stall = 1'b0;
    wait_done(2000);
    check("t2_inputs", 128'(n_in), 128'(8));
    check("t2_results", 128'(n_res), 128'(4));

    // Teacher back-pressure for 5 cycles.
    iReady_BM_Teacher = 1'b0;
    start(1, 8'h22);
    for (int k = 0; k < 20; k++) begin
      if (oValid_BM_Teacher) break;
      tick(1);
    end
    check("t3_teacher_valid", 128'(oValid_BM_Teacher), 128'(1));
    repeat (5) begin
      tick(1);
      check("t3_one_input", 128'(n_in), 128'(1));
      check("t3_addr", 128'(oAddr), 128'(0));
      check("t3_teacher_data", 128'({oValid_BM_Teacher, oData_BM_Teacher}),
            128'({1'b1, 84'h06A069068067066065064}));
    end
    iReady_BM_Teacher = 1'b1;
    wait_done(2000);
    check("t3_teachers", 128'(n_teach), 128'(4));

    // Inference only.
    start(0, 8'h77);
    check("t4_mode", 128'(oMode), 128'(0));
    check("t4_busy", 128'(oBusy), 128'(1));
    wait_done(2000);
    check("t4_teachers", 128'(n_teach), 128'(0));
    check("t4_inputs", 128'(n_in), 128'(4));
    check("t4_results", 128'(n_res), 128'(4));
    check("t4_epoch", 128'(oEpoch), 128'(0));

    // Result back-pressure in inference; a mid-run start must be ignored.
    start(1, 8'h33);
    for (int k = 0; k < 500; k++) begin
      if (!oMode) break;
      tick(1);
    end
    check("t5_infer", 128'(oMode), 128'(0));
    iReady_BM_Result = 1'b0;
    tick(30);
    check("t5_inputs", 128'(n_in), 128'(6));
    check("t5_inflight", 128'(inflight_m), 128'(2));
    check("t5_ready_low", 128'(oReady_AM_Output), 128'(0));
    check("t5_no_results", 128'(n_res), 128'(0));
    iEpochs = 16'd5; iLR = 8'hEE; iStart = 1'b1;
    tick(1);
    iStart = 1'b0;
    tick(3);
    check("t5_ignore_mode", 128'(oMode), 128'(0));
    check("t5_ignore_epoch", 128'(oEpoch), 128'(0));
    iReady_BM_Result = 1'b1;
    wait_done(2000);
    check("t5_total_inputs", 128'(n_in), 128'(8));
    check("t5_results", 128'(n_res), 128'(4));
    tick(3);
    check("t5_done_once", 128'(n_done), 128'(1));

    // Reset during ISSUE of epoch 1.
    start(2, 8'h44);
    for (int k = 0; k < 500; k++) begin
      if (oEpoch == 1 && oValid_BM_Input) break;
      tick(1);
    end
    check("t6_reached_epoch1", 128'({oEpoch, oValid_BM_Input}), 128'({16'd1, 1'b1}));
    iRST = 1'b1;
    tick(1);
    iRST = 1'b0;
    check("t6_valid_in", 128'(oValid_BM_Input), 128'(0));
    check("t6_valid_teach", 128'(oValid_BM_Teacher), 128'(0));
    check("t6_busy", 128'(oBusy), 128'(0));
    check("t6_mode", 128'(oMode), 128'(0));
    check("t6_epoch", 128'(oEpoch), 128'(0));
    net_stall = 1'b1;
    start(0, 8'h55);
    tick(30);
    check("t6_credits_restored", 128'(n_in), 128'(MAXIF));
    net_stall = 1'b0;
    wait_done(2000);
    check("t6_results", 128'(n_res), 128'(4));
    start(1, 8'h66);
    wait_done(2000);
    check("t6_full_inputs", 128'(n_in), 128'(8));
    check("t6_full_results", 128'(n_res), 128'(4));

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
